iterative_subtract_compare: RTL and testbench

- Parametrised, multi-cycle successor to the 32-bit single-cycle subtract/compare unit.
- Computes A − B as A + ~B + 1, processing CHUNK bits per clock with a carry-select slice.
- Produces the difference, carry-out, signed overflow, isNotEqual and a mode-selectable isLessThan (signed or unsigned).
- Sits in the ALU datapath behind a valid/ready handshake so wide operands do not lengthen the critical path.

---
 rtl/iterative_subtract_compare_pkg.sv | 20 ++
 rtl/iterative_subtract_compare_csel_slice.sv | 26 ++
 rtl/iterative_subtract_compare.sv | 158 +++++++++++++++
 tb/tb_iterative_subtract_compare.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iterative_subtract_compare_pkg.sv
// Shared definitions for the iterative subtract/compare unit: FSM encoding
// and helpers that size the slice counter from the operand geometry.
package iterative_subtract_compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-slice configuration still needs a 1-bit counter register.
    function automatic int cnt_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/iterative_subtract_compare_csel_slice.sv
// Combinational carry-select slice: both carry-in cases are summed in
// parallel and the incoming carry only drives the final mux.
module csel_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b_inv,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [CHUNK:0] sum0;
    logic [CHUNK:0] sum1;

    assign sum0 = {1'b0, a} + {1'b0, b_inv};
    assign sum1 = {1'b0, a} + {1'b0, b_inv} + {{CHUNK{1'b0}}, 1'b1};

    assign sum  = cin ? sum1[CHUNK-1:0] : sum0[CHUNK-1:0];
    assign cout = cin ? sum1[CHUNK]     : sum0[CHUNK];

    // Carry into the top bit is recovered from the selected sum bit.
    assign msb_cin = sum[CHUNK-1] ^ a[CHUNK-1] ^ b_inv[CHUNK-1];

endmodule

// File: rtl/iterative_subtract_compare.sv
// Multi-cycle A - B unit: one CHUNK-wide carry-select slice per clock,
// producing difference, carry, signed overflow and compare flags.
module iterative_subtract_compare
    import iterative_subtract_compare_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             cout,
    output logic             overflow,
    output logic             isNotEqual,
    output logic             isLessThan,
    output state_t           fsm_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; out_valid holds with stable data until out_ready.
    localparam int NCHUNK = num_chunks(WIDTH, CHUNK);
    localparam int CW     = cnt_width(NCHUNK);

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_inv_q;
    logic              signed_q;
    logic              carry_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  result_q;
    logic              cout_q;
    logic              ovf_q;
    logic              ne_q;
    logic              lt_q;

    logic              accept;
    logic              last_slice;
    logic [CHUNK-1:0]  a_slice;
    logic [CHUNK-1:0]  b_slice;
    logic [CHUNK-1:0]  slice_sum;
    logic              slice_cout;
    logic              slice_msb_cin;
    logic [WIDTH-1:0]  res_next;
    logic              ovf_next;
    logic              lt_next;

    assign accept     = in_valid & in_ready;
    assign last_slice = (cnt_q == CW'(NCHUNK - 1));

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = BUSY;
            end
            BUSY: begin
                if (last_slice) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The single slice is shared by all positions through a counter-driven mux.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) begin
                a_slice = a_q[i*CHUNK +: CHUNK];
                b_slice = b_inv_q[i*CHUNK +: CHUNK];
            end
        end
    end

    csel_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a       (a_slice),
        .b_inv   (b_slice),
        .cin     (carry_q),
        .sum     (slice_sum),
        .cout    (slice_cout),
        .msb_cin (slice_msb_cin)
    );

    always_comb begin
        res_next = result_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) res_next[i*CHUNK +: CHUNK] = slice_sum;
        end
    end

    assign ovf_next = slice_msb_cin ^ slice_cout;
    assign lt_next  = signed_q ? (slice_sum[CHUNK-1] ^ ovf_next) : ~slice_cout;

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            a_q      <= '0;
            b_inv_q  <= '0;
            signed_q <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ne_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else if (accept) begin
            a_q      <= data_operandA;
            b_inv_q  <= ~data_operandB;
            signed_q <= ctrl_signed;
            carry_q  <= 1'b1;
            cnt_q    <= '0;
        end else if (state_q == BUSY) begin
            result_q <= res_next;
            carry_q  <= slice_cout;
            cnt_q    <= last_slice ? '0 : cnt_q + 1'b1;
            if (last_slice) begin
                cout_q <= slice_cout;
                ovf_q  <= ovf_next;
                ne_q   <= |res_next;
                lt_q   <= lt_next;
            end
        end
    end

    assign data_result = result_q;
    assign cout        = cout_q;
    assign overflow    = ovf_q;
    assign isNotEqual  = ne_q;
    assign isLessThan  = lt_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_iterative_subtract_compare.sv
// Bench for iterative_subtract_compare: three slice widths against an
// arithmetic reference, with directed corner cases and random operands.
module tb_iterative_subtract_compare;
    import iterative_subtract_compare_pkg::*;

    logic        clock;
    logic        rst_n;
    logic        iv   [3];
    logic [31:0] av   [3];
    logic [31:0] bv   [3];
    logic        sg   [3];
    logic        ordy [3];
    logic        irdy [3];
    logic        ov   [3];
    logic [31:0] res  [3];
    logic        co   [3];
    logic        of   [3];
    logic        ne   [3];
    logic        lt   [3];
    state_t      st   [3];

    int n_checks = 0;
    int n_fail   = 0;
    int lat [3]  = '{4, 1, 8};
    logic [35:0] exp_q[$];

    iterative_subtract_compare #(.WIDTH(32), .CHUNK(8)) dut0 (
        .clock(clock), .ctrl_reset_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
        .data_operandA(av[0]), .data_operandB(bv[0]), .ctrl_signed(sg[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .data_result(res[0]), .cout(co[0]),
        .overflow(of[0]), .isNotEqual(ne[0]), .isLessThan(lt[0]), .fsm_state(st[0]));

    iterative_subtract_compare #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clock(clock), .ctrl_reset_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
        .data_operandA(av[1]), .data_operandB(bv[1]), .ctrl_signed(sg[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .data_result(res[1]), .cout(co[1]),
        .overflow(of[1]), .isNotEqual(ne[1]), .isLessThan(lt[1]), .fsm_state(st[1]));

    iterative_subtract_compare #(.WIDTH(32), .CHUNK(4)) dut2 (
        .clock(clock), .ctrl_reset_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
        .data_operandA(av[2]), .data_operandB(bv[2]), .ctrl_signed(sg[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .data_result(res[2]), .cout(co[2]),
        .overflow(of[2]), .isNotEqual(ne[2]), .isLessThan(lt[2]), .fsm_state(st[2]));

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {result, cout, overflow, isNotEqual, isLessThan}
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [32:0] sd;
        logic        c;
        logic        o;
        logic        l;
        sd = {a[31], a} - {b[31], b};
        c  = (a >= b);
        o  = (sd[32] != sd[31]);
        l  = sgn ? ($signed(a) < $signed(b)) : (a < b);
        return {a - b, c, o, (a != b), l};
    endfunction

    function automatic logic [35:0] observed(input int u);
        return {res[u], co[u], of[u], ne[u], lt[u]};
    endfunction

    task automatic check_outputs(input int u, input string tag, input logic [35:0] e);
        logic [35:0] g;
        g = observed(u);
        check({tag, "_result"},   g[35:4], e[35:4]);
        check({tag, "_cout"},     g[3],    e[3]);
        check({tag, "_overflow"}, g[2],    e[2]);
        check({tag, "_ne"},       g[1],    e[1]);
        check({tag, "_lt"},       g[0],    e[0]);
    endtask

    // Driver: present operands on a falling edge and complete the accept edge.
    task automatic send(input int u, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn);
        int w;
        @(negedge clock);
        w = 0;
        while (!irdy[u] && w < 20) begin
            @(negedge clock);
            w++;
        end
        check("in_ready_before_accept", irdy[u], 1'b1);
        iv[u] = 1'b1;
        av[u] = a;
        bv[u] = b;
        sg[u] = sgn;
        exp_q.push_back(model(a, b, sgn));
        @(posedge clock);
        #1;
        iv[u] = 1'b0;
    endtask

    // Waits from just after the accept edge; inputs are scrambled while busy.
    task automatic wait_result(input int u, input bit pop);
        int          cyc;
        logic [35:0] e;
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
            if (ov[u]) break;
            av[u] = $urandom;
            bv[u] = $urandom;
            sg[u] = 1'($urandom_range(0, 1));
            iv[u] = 1'($urandom_range(0, 1));
        end
        iv[u] = 1'b0;
        if (!ov[u]) begin
            check("out_valid_timeout", 1'b0, 1'b1);
            return;
        end
        check("latency", 64'(cyc), 64'(lat[u]));
        check("in_ready_in_done_stalled", irdy[u], 1'b0);
        e = exp_q.pop_front();
        check_outputs(u, "op", e);
        if (pop) begin
            ordy[u] = 1'b1;
            @(posedge clock);
            #1;
            ordy[u] = 1'b0;
            check("out_valid_after_pop", ov[u], 1'b0);
            check("in_ready_after_pop", irdy[u], 1'b1);
        end
    endtask

    task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn);
        send(u, a, b, sgn);
        wait_result(u, 1'b1);
    endtask

    initial begin
        logic [35:0] e;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            iv[u] = 1'b0; av[u] = '0; bv[u] = '0; sg[u] = 1'b0; ordy[u] = 1'b0;
        end
        #12;
        for (int u = 0; u < 3; u++) begin
            check("reset_outputs", observed(u), 36'h0);
            check("reset_out_valid", ov[u], 1'b0);
            check("reset_in_ready", irdy[u], 1'b1);
            check("reset_state", 64'(st[u]), 64'(IDLE));
        end
        @(negedge clock);
        rst_n = 1'b1;

        // Directed cases on every slice width
        for (int u = 0; u < 3; u++) begin
            run_op(u, 32'd5, 32'd3, 1'b0);
            run_op(u, 32'd3, 32'd5, 1'b1);
            run_op(u, 32'd3, 32'd5, 1'b0);
            run_op(u, 32'h8000_0000, 32'h1, 1'b1);
            run_op(u, 32'h8000_0000, 32'h1, 1'b0);
            run_op(u, 32'h1234_ABCD, 32'h1234_ABCD, 1'b0);
            run_op(u, 32'h1234_ABCD, 32'h1234_ABCD, 1'b1);
        end

        // Backpressure then back-to-back accept across a slice boundary
        send(0, 32'hDEAD_BEEF, 32'h0123_4567, 1'b1);
        wait_result(0, 1'b0);
        e = model(32'hDEAD_BEEF, 32'h0123_4567, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            av[0] = $urandom;
            bv[0] = $urandom;
            check_outputs(0, "stall", e);
            check("stall_out_valid", ov[0], 1'b1);
            check("stall_in_ready", irdy[0], 1'b0);
        end
        @(negedge clock);
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        av[0]   = 32'h100;
        bv[0]   = 32'h1;
        sg[0]   = 1'b0;
        #1;
        check("b2b_in_ready", irdy[0], 1'b1);
        exp_q.push_back(model(32'h100, 32'h1, 1'b0));
        @(posedge clock);
        #1;
        iv[0]   = 1'b0;
        ordy[0] = 1'b0;
        check("b2b_out_valid_drop", ov[0], 1'b0);
        wait_result(0, 1'b1);

        // Reset while busy at slice 2
        send(0, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1);
        @(posedge clock);
        @(posedge clock);
        #1;
        check("busy_before_reset", 64'(st[0]), 64'(BUSY));
        rst_n = 1'b0;
        #1;
        check("abort_outputs", observed(0), 36'h0);
        check("abort_out_valid", ov[0], 1'b0);
        check("abort_in_ready", irdy[0], 1'b1);
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        run_op(0, 32'd10, 32'd10, 1'b0);

        // Random operands, biased toward equality and sign-boundary values
        for (int u = 0; u < 3; u++) begin
            for (int n = 0; n < 25; n++) begin
                ra = $urandom;
                rb = $urandom;
                case ($urandom_range(0, 3))
                    0: rb = ra;
                    1: ra = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    2: rb = ra + 32'($urandom_range(0, 2)) - 32'd1;
                    default: ;
                endcase
                run_op(u, ra, rb, 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
